// File: rtl/rom_hdr_scan.sv
// SNES internal-header scanner: snoops the ROM download, scores header candidates, drives mapper/mask/region.
// Define ROMHDR_EXHIROM_EN to capture and score the ExHiROM candidates.
module rom_hdr_scan #(
    parameter int AW     = 25,
    parameter int SC_MIN = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    input  logic [2:0]    force_type,
    output logic [7:0]    rom_type,
    output logic [23:0]   rom_mask,
    output logic [23:0]   ram_mask,
    output logic          rom_pal,
    output logic          hdr_ready,
    output logic          hdr_done
);
    // state   | meaning
    // IDLE    | waiting for a download to start
    // CAPTURE | download active, latching header fields
    // SCORE   | one base scored per cycle: Lo, Hi, ExHi
    // DECIDE  | pick winner, register outputs
    // DONE    | hdr_done pulse, back to IDLE
    typedef enum logic [2:0] {IDLE, CAPTURE, SCORE, DECIDE, DONE} state_t;

    typedef struct packed {
        logic [7:0]  map;
        logic [3:0]  typ;
        logic [7:0]  romsz;
        logic [7:0]  ramsz;
        logic [7:0]  region;
        logic [15:0] cmpl;
        logic [15:0] csum;
        logic [15:0] rvec;
    } hdr_t;

`ifdef ROMHDR_EXHIROM_EN
    localparam int NC = 6;
`else
    localparam int NC = 4;
`endif
    // candidate order: {base, copier} -> Lo, Lo+200, Hi, Hi+200, ExHi, ExHi+200
    localparam logic [23:0] BASE [6] = '{24'h007FC0, 24'h0081C0, 24'h00FFC0,
                                         24'h0101C0, 24'h40FFC0, 24'h4101C0};

    state_t        state_q, state_d;
    logic          dl_q, dl_d;
    hdr_t          hdr_q [NC];
    hdr_t          hdr_d [NC];
    logic [AW-1:0] max_addr_q, max_addr_d;
    logic          copier_q, copier_d;
    logic [2:0]    ft_q, ft_d;
    logic [1:0]    sc_idx_q, sc_idx_d;
    logic [3:0]    score_q [3];
    logic [3:0]    score_d [3];
    logic [7:0]    rom_type_q, rom_type_d;
    logic [23:0]   rom_mask_q, rom_mask_d;
    logic [23:0]   ram_mask_q, ram_mask_d;
    logic          rom_pal_q, rom_pal_d;
    logic          hdr_ready_q, hdr_ready_d;
    logic          hdr_done_q, hdr_done_d;
`ifdef ROMHDR_EXHIROM_EN
    logic          exhi_ok_q, exhi_ok_d;
    logic [AW:0]   size_net;
`endif

    logic [AW:0]   size_w;
    logic          copier_w;
    logic [23:0]   cap_rel;
    logic [1:0]    sel_base, auto_base, dec_base;
    logic [3:0]    best, cand_score, exhi_score;
    logic          use_default;
    hdr_t          cand;
    logic [15:0]   cand_sum;
    logic [7:0]    map_id;
    logic [3:0]    rom_size;
    logic [2:0]    ram_size;
    logic [3:0]    map_nib;

    always_comb begin
        size_w   = {1'b0, max_addr_q} + (AW+1)'(2);
        copier_w = (size_w[9:0] == 10'h200);
`ifdef ROMHDR_EXHIROM_EN
        size_net  = size_w - (copier_w ? (AW+1)'(12'h200) : (AW+1)'(0));
        exhi_ok_d = exhi_ok_q;
`endif
    end

    // winner selection; force_type overrides the score comparison
    always_comb begin
        best      = score_q[0];
        auto_base = 2'd0;
        if (score_q[1] > best) begin best = score_q[1]; auto_base = 2'd1; end
        if (score_q[2] > best) begin best = score_q[2]; auto_base = 2'd2; end
        use_default = 1'b0;
        dec_base    = auto_base;
        case (ft_q)
            3'd1: begin dec_base = 2'd0; use_default = 1'b1; end
            3'd2: dec_base = 2'd0;
            3'd3: dec_base = 2'd1;
`ifdef ROMHDR_EXHIROM_EN
            3'd4: dec_base = 2'd2;
`else
            3'd4: dec_base = 2'd1;
`endif
            default: if (best < 4'(SC_MIN)) begin dec_base = 2'd0; use_default = 1'b1; end
        endcase
        sel_base = (state_q == DECIDE) ? dec_base : sc_idx_q;
    end

    always_comb begin
        cand = '0;
        case (sel_base)
            2'd0: cand = copier_q ? hdr_q[1] : hdr_q[0];
            2'd1: cand = copier_q ? hdr_q[3] : hdr_q[2];
`ifdef ROMHDR_EXHIROM_EN
            2'd2: cand = copier_q ? hdr_q[5] : hdr_q[4];
`endif
            default: cand = '0;
        endcase
        cand_sum   = cand.csum + cand.cmpl;
        map_id     = (sel_base == 2'd0) ? 8'h20 : (sel_base == 2'd1) ? 8'h21 : 8'h25;
        map_nib    = (sel_base == 2'd0) ? 4'h0 : (sel_base == 2'd1) ? 4'h1 : 4'h5;
        cand_score = 4'd0;
        if (cand_sum == 16'hFFFF)                   cand_score = cand_score + 4'd4;
        if ((cand.map & 8'hEF) == map_id)           cand_score = cand_score + 4'd2;
        if (cand.rvec >= 16'h8000)                  cand_score = cand_score + 4'd2;
        if (cand.romsz >= 8'd8 && cand.romsz <= 8'd13) cand_score = cand_score + 4'd1;
        if (cand.ramsz <= 8'd7)                     cand_score = cand_score + 4'd1;
`ifdef ROMHDR_EXHIROM_EN
        exhi_score = exhi_ok_q ? cand_score : 4'd0;
`else
        exhi_score = 4'd0;
`endif
        rom_size = (cand.romsz >= 8'd8 && cand.romsz <= 8'd13) ? cand.romsz[3:0] : 4'hC;
        ram_size = (cand.ramsz > 8'd7) ? 3'd7 : cand.ramsz[2:0];
    end

    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        hdr_d       = hdr_q;
        max_addr_d  = max_addr_q;
        copier_d    = copier_q;
        ft_d        = ft_q;
        sc_idx_d    = sc_idx_q;
        score_d     = score_q;
        rom_type_d  = rom_type_q;
        rom_mask_d  = rom_mask_q;
        ram_mask_d  = ram_mask_q;
        rom_pal_d   = rom_pal_q;
        hdr_ready_d = hdr_ready_q;
        hdr_done_d  = 1'b0;
        cap_rel     = '0;
        if (ioctl_download && !dl_q) begin
            // a new image always restarts capture, even mid-scoring
            state_d     = CAPTURE;
            max_addr_d  = '0;
            hdr_ready_d = 1'b0;
            for (int c = 0; c < NC; c++) hdr_d[c] = '0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (ioctl_download && ioctl_wr) begin
                        if (ioctl_addr > max_addr_q) max_addr_d = ioctl_addr;
                        if ((ioctl_addr >> 24) == '0) begin
                            for (int c = 0; c < NC; c++) begin
                                cap_rel = ioctl_addr[23:0] - BASE[c];
                                case (cap_rel)
                                    24'h14: hdr_d[c].map = ioctl_dout[15:8];
                                    24'h16: begin
                                        hdr_d[c].typ   = ioctl_dout[7:4];
                                        hdr_d[c].romsz = ioctl_dout[15:8];
                                    end
                                    24'h18: begin
                                        hdr_d[c].ramsz  = ioctl_dout[7:0];
                                        hdr_d[c].region = ioctl_dout[15:8];
                                    end
                                    24'h1C: hdr_d[c].cmpl = ioctl_dout;
                                    24'h1E: hdr_d[c].csum = ioctl_dout;
                                    24'h3C: hdr_d[c].rvec = ioctl_dout;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    if (dl_q && !ioctl_download) begin
                        state_d  = SCORE;
                        copier_d = copier_w;
                        ft_d     = force_type;
                        sc_idx_d = 2'd0;
`ifdef ROMHDR_EXHIROM_EN
                        exhi_ok_d = (size_net > (AW+1)'(24'h400000));
`endif
                    end
                end
                SCORE: begin
                    case (sc_idx_q)
                        2'd0:    score_d[0] = cand_score;
                        2'd1:    score_d[1] = cand_score;
                        default: score_d[2] = exhi_score;
                    endcase
                    if (sc_idx_q == 2'd2) state_d = DECIDE;
                    else sc_idx_d = sc_idx_q + 2'd1;
                end
                DECIDE: begin
                    rom_type_d  = use_default ? 8'h00 : {cand.typ, map_nib};
                    rom_mask_d  = use_default ? 24'h3FFFFF : (24'd1024 << rom_size) - 24'd1;
                    ram_mask_d  = (use_default || cand.ramsz == 8'd0) ? 24'h0
                                : (24'd1024 << ram_size) - 24'd1;
                    rom_pal_d   = (cand.region >= 8'h02 && cand.region <= 8'h0C);
                    hdr_ready_d = 1'b1;
                    hdr_done_d  = 1'b1;
                    state_d     = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q     <= IDLE;
            // held high so a download already in progress is not taken as a new image
            dl_q        <= 1'b1;
            for (int c = 0; c < NC; c++) hdr_q[c] <= '0;
            max_addr_q  <= '0;
            copier_q    <= 1'b0;
            ft_q        <= 3'd0;
            sc_idx_q    <= 2'd0;
            for (int i = 0; i < 3; i++) score_q[i] <= 4'd0;
            rom_type_q  <= 8'h00;
            rom_mask_q  <= 24'h3FFFFF;
            ram_mask_q  <= 24'h0;
            rom_pal_q   <= 1'b0;
            hdr_ready_q <= 1'b0;
            hdr_done_q  <= 1'b0;
`ifdef ROMHDR_EXHIROM_EN
            exhi_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            hdr_q       <= hdr_d;
            max_addr_q  <= max_addr_d;
            copier_q    <= copier_d;
            ft_q        <= ft_d;
            sc_idx_q    <= sc_idx_d;
            score_q     <= score_d;
            rom_type_q  <= rom_type_d;
            rom_mask_q  <= rom_mask_d;
            ram_mask_q  <= ram_mask_d;
            rom_pal_q   <= rom_pal_d;
            hdr_ready_q <= hdr_ready_d;
            hdr_done_q  <= hdr_done_d;
`ifdef ROMHDR_EXHIROM_EN
            exhi_ok_q   <= exhi_ok_d;
`endif
        end
    end

    assign rom_type  = rom_type_q;
    assign rom_mask  = rom_mask_q;
    assign ram_mask  = ram_mask_q;
    assign rom_pal   = rom_pal_q;
    assign hdr_ready = hdr_ready_q;
    assign hdr_done  = hdr_done_q;
endmodule

// File: tb/tb_rom_hdr_scan.sv
// Directed bench for rom_hdr_scan: header images with hand-computed mapper/mask/region results.
module tb_rom_hdr_scan;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [2:0]  force_type;
    logic [7:0]  rom_type;
    logic [23:0] rom_mask;
    logic [23:0] ram_mask;
    logic        rom_pal;
    logic        hdr_ready;
    logic        hdr_done;

    int n_chk  = 0;
    int n_fail = 0;

    rom_hdr_scan dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .force_type(force_type),
        .rom_type(rom_type), .rom_mask(rom_mask), .ram_mask(ram_mask),
        .rom_pal(rom_pal), .hdr_ready(hdr_ready), .hdr_done(hdr_done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [24:0] a, input logic [15:0] d);
        @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic put_hdr(input logic [24:0] base, input logic [7:0] map, input logic [7:0] typ,
                           input logic [7:0] romsz, input logic [7:0] ramsz, input logic [7:0] region,
                           input logic [15:0] csum, input logic [15:0] cmpl, input logic [15:0] rvec);
        wr(base + 25'h14, {map, 8'h00});
        wr(base + 25'h16, {romsz, typ});
        wr(base + 25'h18, {region, ramsz});
        wr(base + 25'h1C, cmpl);
        wr(base + 25'h1E, csum);
        wr(base + 25'h3C, rvec);
    endtask

    task automatic dl_start();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
    endtask

    // drop download and check the decision appears exactly five cycles later
    task automatic dl_finish(input string tag, input logic [2:0] ft_after, input logic [7:0] e_type,
                             input logic [23:0] e_rmask, input logic [23:0] e_ram, input logic e_pal);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        force_type = ft_after;
        repeat (2) @(negedge clk_sys);
        chk({tag, "_done_early"}, 32'(hdr_done), 32'd0);
        @(negedge clk_sys);
        chk({tag, "_done"},     32'(hdr_done),  32'd1);
        chk({tag, "_ready"},    32'(hdr_ready), 32'd1);
        chk({tag, "_rom_type"}, 32'(rom_type),  32'(e_type));
        chk({tag, "_rom_mask"}, 32'(rom_mask),  32'(e_rmask));
        chk({tag, "_ram_mask"}, 32'(ram_mask),  32'(e_ram));
        chk({tag, "_rom_pal"},  32'(rom_pal),   32'(e_pal));
        @(negedge clk_sys);
        chk({tag, "_done_pulse"}, 32'(hdr_done), 32'd0);
    endtask

    task automatic img_t1();
        put_hdr(25'h7FC0, 8'h20, 8'h02, 8'h0A, 8'h03, 8'h01, 16'h1234, 16'hEDCB, 16'h8000);
        wr(25'h0FFFFE, 16'h0000);
    endtask

    task automatic img_t3();
        put_hdr(25'hFFC0,   8'h21, 8'h00, 8'h0D, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        put_hdr(25'h40FFC0, 8'h25, 8'h00, 8'h0D, 8'h00, 8'h01, 16'h0F0F, 16'hF0F0, 16'hC000);
        wr(25'h5FFFFE, 16'h0000);
    endtask

    task automatic img_t5a();
        put_hdr(25'h7FC0, 8'h30, 8'h35, 8'h0B, 8'h05, 8'h0C, 16'h0001, 16'hFFFE, 16'hFFFC);
        put_hdr(25'hFFC0, 8'h31, 8'h10, 8'h09, 8'h01, 8'h00, 16'h8000, 16'h7FFF, 16'h8000);
        wr(25'h1FFFFE, 16'h0000);
    endtask

    initial begin
        logic seen;
        reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; force_type = 3'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_rom_type", 32'(rom_type), 32'h0);
        chk("rst_rom_mask", 32'(rom_mask), 32'h3FFFFF);
        chk("rst_ram_mask", 32'(ram_mask), 32'h0);
        chk("rst_rom_pal",  32'(rom_pal),  32'h0);
        chk("rst_ready",    32'(hdr_ready), 32'h0);
        chk("rst_done",     32'(hdr_done),  32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);

        dl_start(); img_t1();
        dl_finish("t1", 3'd0, 8'h00, 24'h0FFFFF, 24'h001FFF, 1'b0);

        // HiROM with copier; ExHi sits exactly at the 4 MB boundary and must score 0
        dl_start();
        put_hdr(25'h101C0, 8'h21, 8'h02, 8'h0C, 8'h00, 8'h02, 16'hA5A5, 16'h5A5A, 16'h8000);
        wr(25'h4001FE, 16'h0000);
        dl_finish("t2", 3'd0, 8'h01, 24'h3FFFFF, 24'h0, 1'b1);

        dl_start(); img_t3();
`ifdef ROMHDR_EXHIROM_EN
        dl_finish("t3", 3'd0, 8'h05, 24'h7FFFFF, 24'h0, 1'b0);
`else
        dl_finish("t3", 3'd0, 8'h01, 24'h7FFFFF, 24'h0, 1'b0);
`endif

        dl_start(); wr(25'h0FFFFE, 16'h0000);
        dl_finish("t4_auto", 3'd0, 8'h00, 24'h3FFFFF, 24'h0, 1'b0);

        // forced HiROM; the late change back to auto must be ignored
        force_type = 3'd3;
        dl_start(); wr(25'h0FFFFE, 16'h0000);
        dl_finish("t4_force3", 3'd0, 8'h01, 24'h3FFFFF, 24'h0, 1'b0);

        force_type = 3'd1;
        dl_start(); img_t5a();
        dl_finish("force1", 3'd1, 8'h00, 24'h3FFFFF, 24'h0, 1'b1);
        force_type = 3'd0;

        dl_start(); img_t5a();
        dl_finish("t5_tie", 3'd0, 8'h30, 24'h1FFFFF, 24'h007FFF, 1'b1);

        dl_start();
        put_hdr(25'h7FC0, 8'h20, 8'h20, 8'h0F, 8'h09, 8'h0D, 16'h1111, 16'hEEEE, 16'h8000);
        wr(25'h0FFFFE, 16'h0000);
        dl_finish("t5_clamp", 3'd0, 8'h20, 24'h3FFFFF, 24'h01FFFF, 1'b0);

        // over-24-bit writes: alias into the Lo+200 header is ignored, size still grows to give a copier
        dl_start();
        put_hdr(25'h81C0, 8'h20, 8'h00, 8'h0A, 8'h02, 8'h05, 16'h4321, 16'hBCDE, 16'h8000);
        wr(25'h10081D6, {8'h0D, 8'hF0});
        wr(25'h10085FE, 16'h0000);
        dl_finish("t7_hiaddr", 3'd0, 8'h00, 24'h0FFFFF, 24'h000FFF, 1'b1);

        // abort during SCORE cycle 2
        dl_start(); img_t3();
        @(negedge clk_sys); ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("t6_ready_cleared", 32'(hdr_ready), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_sys);
            if (hdr_done) seen = 1'b1;
        end
        chk("t6_no_done", 32'(seen), 32'd0);
        chk("t6_mask_held", 32'(rom_mask), 32'h0FFFFF);
        img_t5a();
        dl_finish("t6_recap", 3'd0, 8'h30, 24'h1FFFFF, 24'h007FFF, 1'b1);

        // reset during CAPTURE, then no capture until a fresh rising edge
        dl_start(); wr(25'h7FD4, 16'h2000);
        @(negedge clk_sys); reset = 1'b0;
        @(negedge clk_sys);
        chk("t8_rom_type", 32'(rom_type), 32'h0);
        chk("t8_rom_mask", 32'(rom_mask), 32'h3FFFFF);
        chk("t8_ram_mask", 32'(ram_mask), 32'h0);
        chk("t8_rom_pal",  32'(rom_pal),  32'h0);
        chk("t8_ready",    32'(hdr_ready), 32'h0);
        @(negedge clk_sys); reset = 1'b1;
        img_t1();
        @(negedge clk_sys); ioctl_download = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk_sys);
            if (hdr_done || hdr_ready) seen = 1'b1;
        end
        chk("t8_no_decision", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
